// File: rtl/comb_logic_lut_pkg.sv
// Shared types and the truth-table lookup used by every lane of comb_logic_lut.
// The table index is {a,b,c}: a is the MSB and c is the LSB.
package comb_logic_lut_pkg;

  typedef logic [7:0] tt_t;

  // Minterms 000, 100 and 101: y = (~b & ~c) | (a & ~b)
  localparam tt_t TT_DEFAULT = 8'h31;

  function automatic logic tt_eval(tt_t tt, logic a, logic b, logic c);
    return tt[{a, b, c}];
  endfunction

endpackage

// File: rtl/comb_logic_lut_lane.sv
// Single-lane three-input lookup. The lane is purely combinational and has no clock or reset.
module comb_logic_lut_lane
  import comb_logic_lut_pkg::*;
(
  input  tt_t  tt,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = tt_eval(tt, a, b, c);

endmodule

// File: rtl/comb_logic_lut.sv
// LANES-wide three-input truth-table function with a combinational output and a registered output.
// Optional feature macro: COMB_LOGIC_LUT_TT_PROG_EN adds a runtime-writable table register.
module comb_logic_lut
  import comb_logic_lut_pkg::*;
#(
  parameter int  LANES       = 1,
  parameter tt_t TRUTH_TABLE = TT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] c,
  input  logic             in_valid,
`ifdef COMB_LOGIC_LUT_TT_PROG_EN
  input  logic             tt_wr_en,
  input  tt_t              tt_wr_data,
`endif
  output logic [LANES-1:0] y,
  output logic [LANES-1:0] y_q,
  output logic             out_valid
);

  tt_t tt;

`ifdef COMB_LOGIC_LUT_TT_PROG_EN
  tt_t tt_q;

  // A write lands on the clock edge, so a capture in the same cycle still sees the old table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q <= TRUTH_TABLE;
    end else if (tt_wr_en) begin
      tt_q <= tt_wr_data;
    end
  end

  assign tt = tt_q;
`else
  assign tt = TRUTH_TABLE;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    comb_logic_lut_lane u_lane (
      .tt (tt),
      .a  (a[i]),
      .b  (b[i]),
      .c  (c[i]),
      .y  (y[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q <= y;
      end
    end
  end

endmodule

// File: tb/tb_comb_logic_lut.sv
// Directed bench for comb_logic_lut: one single-lane and one four-lane instance on a shared clock and reset.
// Table-programming checks build only when COMB_LOGIC_LUT_TT_PROG_EN is defined.
module tb_comb_logic_lut;
  import comb_logic_lut_pkg::*;

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic y;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, c1, iv1;
  logic       y1, yq1, ov1;
  logic [3:0] a4, b4, c4, y4, yq4;
  logic       iv4, ov4;
  logic       tt_wr_en1, tt_wr_en4;
  tt_t        tt_wr_data1, tt_wr_data4;

  int   passed = 0;
  int   total  = 0;
  vec_t vecs[8];

  comb_logic_lut #(.LANES(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a1),
    .b          (b1),
    .c          (c1),
    .in_valid   (iv1),
`ifdef COMB_LOGIC_LUT_TT_PROG_EN
    .tt_wr_en   (tt_wr_en1),
    .tt_wr_data (tt_wr_data1),
`endif
    .y          (y1),
    .y_q        (yq1),
    .out_valid  (ov1)
  );

  comb_logic_lut #(.LANES(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a4),
    .b          (b4),
    .c          (c4),
    .in_valid   (iv4),
`ifdef COMB_LOGIC_LUT_TT_PROG_EN
    .tt_wr_en   (tt_wr_en4),
    .tt_wr_data (tt_wr_data4),
`endif
    .y          (y4),
    .y_q        (yq4),
    .out_valid  (ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic set1(input logic a, input logic b, input logic c);
    a1 = a;
    b1 = b;
    c1 = c;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    set1(1'b0, 1'b0, 1'b0);
    iv1 = 1'b0;
    a4 = '0; b4 = '0; c4 = '0; iv4 = 1'b0;
    tt_wr_en1 = 1'b0; tt_wr_data1 = '0;
    tt_wr_en4 = 1'b0; tt_wr_data4 = '0;

    #12;
    check("reset_yq1", yq1, 0);
    check("reset_ov1", ov1, 0);
    check("reset_yq4", yq4, 0);
    check("reset_ov4", ov4, 0);
    check("reset_y1_live", y1, 1);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational sweep of all eight input combinations
    for (int i = 0; i < 8; i++) begin
      set1(vecs[i].a, vecs[i].b, vecs[i].c);
      #1;
      check($sformatf("sweep_y_%0d", i), y1, vecs[i].y);
      @(negedge clk);
    end
    check("sweep_no_capture", yq1, 0);

    set1(1'b1, 1'b0, 1'b1);
    iv1 = 1'b1;
    @(negedge clk);
    check("cap101_yq", yq1, 1);
    check("cap101_ov", ov1, 1);
    set1(1'b0, 1'b1, 1'b0);
    iv1 = 1'b0;
    @(negedge clk);
    check("hold_yq", yq1, 1);
    check("hold_ov", ov1, 0);
    check("hold_y", y1, 0);

    // Async reset between edges, with a capture pending
    set1(1'b1, 1'b0, 1'b0);
    iv1 = 1'b1;
    @(negedge clk);
    check("pre_rst_ov", ov1, 1);
    check("pre_rst_yq", yq1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_yq", yq1, 0);
    check("async_rst_ov", ov1, 0);
    set1(1'b0, 1'b1, 1'b1);
    #1;
    check("rst_y_tracks", y1, 0);
    set1(1'b0, 1'b0, 1'b0);
    #1;
    check("rst_y_tracks2", y1, 1);
    @(negedge clk);
    check("rst_held_yq", yq1, 0);
    check("rst_held_ov", ov1, 0);
    iv1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_yq", yq1, 0);
    check("post_rst_ov", ov1, 0);
    iv1 = 1'b1;
    @(negedge clk);
    check("first_cap_yq", yq1, 1);
    check("first_cap_ov", ov1, 1);
    iv1 = 1'b0;

    // Four independent lanes
    a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b0110; iv4 = 1'b1;
    #1;
    check("lanes4_y", y4, 4'b0101);
    @(negedge clk);
    check("lanes4_yq", yq4, 4'b0101);
    check("lanes4_ov", ov4, 1);
    a4 = 4'b1111; b4 = 4'b0000; c4 = 4'b0101; iv4 = 1'b0;
    #1;
    check("lanes4_y2", y4, 4'b1111);
    @(negedge clk);
    check("lanes4_hold_yq", yq4, 4'b0101);
    a4 = 4'b0011; b4 = 4'b0101; c4 = 4'b1110; iv4 = 1'b1;
    #1;
    check("lanes4_y3", y4, 4'b0010);
    @(negedge clk);
    check("lanes4_yq3", yq4, 4'b0010);
    iv4 = 1'b0;

`ifdef COMB_LOGIC_LUT_TT_PROG_EN
    // Write AND3 while capturing 000: the capture must use the old table
    set1(1'b0, 1'b0, 1'b0);
    iv1 = 1'b1;
    tt_wr_en1 = 1'b1;
    tt_wr_data1 = 8'h80;
    #1;
    check("prog_old_y", y1, 1);
    @(negedge clk);
    tt_wr_en1 = 1'b0;
    iv1 = 1'b0;
    check("prog_same_cycle_yq", yq1, 1);
    check("prog_new_y000", y1, 0);
    set1(1'b1, 1'b1, 1'b1);
    #1;
    check("prog_and3_111", y1, 1);
    set1(1'b1, 1'b0, 1'b1);
    #1;
    check("prog_and3_101", y1, 0);
    check("prog_other_inst", y4, 4'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("prog_rst_restores", y1, 1);
    @(negedge clk);
`endif

    // Back-to-back captures cycling 000..111
    check("b2b_pre_ov", ov1, 0);
    set1(vecs[0].a, vecs[0].b, vecs[0].c);
    iv1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_yq_%0d", i), yq1, vecs[i].y);
      check($sformatf("b2b_ov_%0d", i), ov1, 1);
      if (i < 7) begin
        set1(vecs[i+1].a, vecs[i+1].b, vecs[i+1].c);
      end else begin
        iv1 = 1'b0;
        set1(1'b0, 1'b0, 1'b0);
      end
    end
    @(negedge clk);
    check("b2b_post_ov", ov1, 0);
    check("b2b_post_yq", yq1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
